// File: rtl/otter_mdu.sv
// otter_mdu: multi-cycle RV32M multiply/divide unit for the Otter execute stage.
// Shift-add multiply and restoring divide, one bit per cycle, on a shared
// 2*WIDTH accumulator. Define OTTER_MDU_FAST_MUL_EN to replace the iterative
// multiply with a single combinational product (divides stay iterative).
module otter_mdu #(
  parameter int WIDTH = 32,
  parameter int CNT_W = $clog2(WIDTH) + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             kill,
  input  logic [2:0]       func,
  input  logic [WIDTH-1:0] src_a,
  input  logic [WIDTH-1:0] src_b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] CALC  = 2'd1;
  localparam logic [1:0] FINAL = 2'd2;

  localparam logic [WIDTH-1:0] MOST_NEG = {1'b1, {(WIDTH-1){1'b0}}};

  logic [1:0]         state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0]   mcand_q, mcand_d;
  logic               neg_q, neg_d;
  logic [2:0]         func_q, func_d;
  logic               done_q, done_d;
  logic [WIDTH-1:0]   result_q, result_d;

  // Operand decode: signedness per op, magnitudes and divide special cases.
  logic             is_div, sa_en, sb_en, sa, sb, div_zero, ovf;
  logic [WIDTH-1:0] mag_a, mag_b;

  assign is_div   = func[2];
  assign sa_en    = func[2] ? ~func[0] : (func[1:0] != 2'b11);
  assign sb_en    = func[2] ? ~func[0] : ~func[1];
  assign sa       = sa_en & src_a[WIDTH-1];
  assign sb       = sb_en & src_b[WIDTH-1];
  assign mag_a    = sa ? -src_a : src_a;
  assign mag_b    = sb ? -src_b : src_b;
  assign div_zero = (src_b == '0);
  assign ovf      = func[2] & ~func[0] & (src_a == MOST_NEG) & (&src_b);

`ifdef OTTER_MDU_FAST_MUL_EN
  logic [2*WIDTH-1:0] fast_prod;
  assign fast_prod = {{WIDTH{1'b0}}, mag_a} * {{WIDTH{1'b0}}, mag_b};
`endif

  // One iteration step: acc low half holds the multiplier (shifted out) or the
  // dividend (shifted out, quotient bits shifted in); high half is the partial
  // product or partial remainder.
  logic [WIDTH:0]     mul_sum, div_trial;
  logic [2*WIDTH-1:0] mul_next, div_next;

  assign mul_sum   = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, mcand_q} : '0);
  assign mul_next  = {mul_sum, acc_q[WIDTH-1:1]};
  assign div_trial = acc_q[2*WIDTH-1:WIDTH-1] - {1'b0, mcand_q};
  assign div_next  = div_trial[WIDTH] ? {acc_q[2*WIDTH-2:0], 1'b0}
                                      : {div_trial[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};

  // Final sign correction and half/quotient/remainder selection.
  logic [2*WIDTH-1:0] prod;
  logic [WIDTH-1:0]   div_val, div_res, fin_res;

  assign prod    = neg_q ? -acc_q : acc_q;
  assign div_val = func_q[1] ? acc_q[2*WIDTH-1:WIDTH] : acc_q[WIDTH-1:0];
  assign div_res = neg_q ? -div_val : div_val;

  // Result mux for the FINAL state.
  always_comb begin
    fin_res = div_res;
    if (!func_q[2]) fin_res = (func_q[1:0] == 2'b00) ? prod[WIDTH-1:0] : prod[2*WIDTH-1:WIDTH];
  end

  // Next-state logic; kill overrides everything and leaves result untouched.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    acc_d    = acc_q;
    mcand_d  = mcand_q;
    neg_d    = neg_q;
    func_d   = func_q;
    done_d   = 1'b0;
    result_d = result_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          func_d  = func;
          cnt_d   = CNT_W'(WIDTH);
          mcand_d = is_div ? mag_b : mag_a;
          // REM takes the dividend sign; everything else the xor of signs.
          neg_d   = (func[2] & func[1]) ? sa : (sa ^ sb);
          if (is_div && div_zero) begin
            acc_d   = {src_a, {WIDTH{1'b1}}};
            neg_d   = 1'b0;
            state_d = FINAL;
          end else if (ovf) begin
            acc_d   = {{WIDTH{1'b0}}, src_a};
            neg_d   = 1'b0;
            state_d = FINAL;
          end else if (is_div) begin
            acc_d   = {{WIDTH{1'b0}}, mag_a};
            state_d = CALC;
          end else begin
`ifdef OTTER_MDU_FAST_MUL_EN
            acc_d   = fast_prod;
            state_d = FINAL;
`else
            acc_d   = {{WIDTH{1'b0}}, mag_b};
            state_d = CALC;
`endif
          end
        end
      end
      CALC: begin
        acc_d = func_q[2] ? div_next : mul_next;
        cnt_d = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) state_d = FINAL;
      end
      FINAL: begin
        result_d = fin_res;
        done_d   = 1'b1;
        state_d  = IDLE;
      end
      default: state_d = IDLE;
    endcase
    if (kill) begin
      state_d  = IDLE;
      done_d   = 1'b0;
      result_d = result_q;
    end
  end

  // State registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      acc_q    <= '0;
      mcand_q  <= '0;
      neg_q    <= 1'b0;
      func_q   <= '0;
      done_q   <= 1'b0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      acc_q    <= acc_d;
      mcand_q  <= mcand_d;
      neg_q    <= neg_d;
      func_q   <= func_d;
      done_q   <= done_d;
      result_q <= result_d;
    end
  end

  assign busy   = (state_q != IDLE);
  assign done   = done_q;
  assign result = result_q;

endmodule

// File: tb/tb_otter_mdu.sv
// tb_otter_mdu: scoreboard bench for otter_mdu (WIDTH=32). Expected results and
// due cycles are queued at issue and checked when done pulses.
module tb_otter_mdu;

`ifdef OTTER_MDU_FAST_MUL_EN
  localparam int MUL_LAT = 1;
`else
  localparam int MUL_LAT = 33;
`endif
  localparam int DIV_LAT = 33;

  logic        clk = 1'b0;
  logic        rst_n, start, kill;
  logic [2:0]  func;
  logic [31:0] src_a, src_b;
  logic        busy, done;
  logic [31:0] result;

  otter_mdu dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .kill  (kill),
    .func  (func),
    .src_a (src_a),
    .src_b (src_b),
    .busy  (busy),
    .done  (done),
    .result(result)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] res;
    int          due;
    string       tag;
  } exp_t;

  exp_t q[$];
  int   cyc = 0;
  int   n_cmp = 0;
  int   n_err = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  // Done monitor: pops the scoreboard and checks value, latency and exclusivity.
  always @(posedge clk) begin
    #1;
    cyc++;
    if (done) begin
      if (q.size() == 0) begin
        check_eq("spurious_done", 32'(done), 32'd0);
      end else begin
        exp_t e;
        e = q.pop_front();
        check_eq(e.tag, result, e.res);
        check_eq({e.tag, "_lat"}, 32'(cyc), 32'(e.due));
        check_eq({e.tag, "_busy_excl"}, 32'(busy), 32'd0);
      end
    end
  end

  // Issue one op, count busy cycles until done, and check the busy window.
  task automatic run_op(input string tag, input logic [2:0] f, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] exp, input int lat);
    exp_t e;
    int   nbusy;
    bit   seen;
    @(negedge clk);
    start = 1'b1; func = f; src_a = a; src_b = b;
    @(posedge clk);
    #2;
    e.res = exp; e.due = cyc + lat; e.tag = tag;
    q.push_back(e);
    nbusy = busy ? 1 : 0;
    seen  = 1'b0;
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < 100 && !seen; i++) begin
      @(posedge clk);
      #2;
      if (done) seen = 1'b1;
      else if (busy) nbusy++;
    end
    check_eq({tag, "_done_seen"}, 32'(seen), 32'd1);
    check_eq({tag, "_busy_cycles"}, 32'(nbusy), 32'(lat));
  endtask

  task automatic wait_done(input string tag);
    bit seen = 1'b0;
    for (int i = 0; i < 100 && !seen; i++) begin
      @(posedge clk);
      #2;
      if (done) seen = 1'b1;
    end
    check_eq({tag, "_done_seen"}, 32'(seen), 32'd1);
  endtask

  initial begin
    exp_t e;
    rst_n = 1'b0; start = 1'b0; kill = 1'b0; func = '0; src_a = '0; src_b = '0;
    repeat (2) @(posedge clk);
    #2;
    check_eq("rst_busy", 32'(busy), 32'd0);
    check_eq("rst_done", 32'(done), 32'd0);
    check_eq("rst_result", result, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Multiplies
    run_op("mul_neg2x3",   3'b000, 32'hFFFF_FFFE, 32'd3,         32'hFFFF_FFFA, MUL_LAT);
    run_op("mulh_neg2x3",  3'b001, 32'hFFFF_FFFE, 32'd3,         32'hFFFF_FFFF, MUL_LAT);
    run_op("mulhu_ones",   3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, MUL_LAT);
    run_op("mulhsu_ones",  3'b010, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, MUL_LAT);
    run_op("mul_pos",      3'b000, 32'd12345,     32'd6789,      32'd83810205,  MUL_LAT);

    // Divides
    run_op("div_neg7_2",   3'b100, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFD, DIV_LAT);
    run_op("rem_neg7_2",   3'b110, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, DIV_LAT);
    run_op("divu_100_7",   3'b101, 32'd100,       32'd7,         32'd14,        DIV_LAT);
    run_op("remu_100_7",   3'b111, 32'd100,       32'd7,         32'd2,         DIV_LAT);
    run_op("div_7_neg2",   3'b100, 32'd7,         32'hFFFF_FFFE, 32'hFFFF_FFFD, DIV_LAT);

    // Special cases
    run_op("divu_by0",     3'b101, 32'd5,         32'd0,         32'hFFFF_FFFF, 1);
    run_op("div_ovf",      3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1);
    run_op("rem_ovf",      3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0,         1);
    run_op("rem_by0",      3'b110, 32'hFFFF_FFF9, 32'd0,         32'hFFFF_FFF9, 1);
    run_op("remu_by0",     3'b111, 32'd5,         32'd0,         32'd5,         1);

    // Kill 10 cycles into a DIV: result must stay at 5.
    @(negedge clk);
    start = 1'b1; func = 3'b100; src_a = 32'd1000; src_b = 32'd3;
    @(negedge clk);
    start = 1'b0;
    repeat (9) @(negedge clk);
    kill = 1'b1;
    @(posedge clk);
    #2;
    check_eq("kill_busy", 32'(busy), 32'd0);
    check_eq("kill_done", 32'(done), 32'd0);
    check_eq("kill_result", result, 32'd5);
    @(negedge clk);
    kill = 1'b0;
    repeat (40) @(posedge clk);
    #2;
    check_eq("kill_result_hold", result, 32'd5);

    // kill with start in IDLE: start ignored.
    @(negedge clk);
    start = 1'b1; kill = 1'b1;
    @(posedge clk);
    #2;
    check_eq("kill_start_busy", 32'(busy), 32'd0);
    @(negedge clk);
    start = 1'b0; kill = 1'b0;
    run_op("div_after_kill", 3'b100, 32'd1000, 32'd3, 32'd333, DIV_LAT);

    // start held through an op, then a new op accepted in the done cycle.
    @(negedge clk);
    start = 1'b1; func = 3'b101; src_a = 32'd100; src_b = 32'd7;
    @(posedge clk);
    #2;
    e.res = 32'd14; e.due = cyc + DIV_LAT; e.tag = "hold_divu";
    q.push_back(e);
    wait_done("hold_divu");
    @(negedge clk);
    func = 3'b111;
    @(posedge clk);
    #2;
    e.res = 32'd2; e.due = cyc + DIV_LAT; e.tag = "b2b_remu";
    q.push_back(e);
    check_eq("b2b_busy", 32'(busy), 32'd1);
    @(negedge clk);
    start = 1'b0;
    wait_done("b2b_remu");

    // Asynchronous reset mid-CALC.
    @(negedge clk);
    start = 1'b1; func = 3'b100; src_a = 32'd99; src_b = 32'd4;
    @(negedge clk);
    start = 1'b0;
    repeat (5) @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    check_eq("arst_busy", 32'(busy), 32'd0);
    check_eq("arst_done", 32'(done), 32'd0);
    check_eq("arst_result", result, 32'd0);
    #3;
    rst_n = 1'b1;
    repeat (45) @(posedge clk);
    run_op("mul_after_rst", 3'b000, 32'd5, 32'd7, 32'd35, MUL_LAT);

    repeat (3) @(posedge clk);
    #2;
    check_eq("queue_empty", 32'(q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/otter_mdu.md
Name: otter_mdu

Overview:
- Parametrised multi-cycle multiply/divide unit implementing the RV32M operations for the Otter core.
- Sits beside the combinational ALU in the execute stage.
- Core issues `start` with operands; the unit asserts `busy`, iterates one bit per cycle, then returns a registered `result` with a one-cycle `done` pulse.
- A `kill` input aborts an in-flight operation on pipeline flush.

Parameters:
- WIDTH, 32, operand/result width in bits; must be even and >= 8.
- CNT_W, $clog2(WIDTH)+1, iteration counter width; derived, do not override.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- start  input  1  issue request; sampled only in IDLE
- kill  input  1  abort current/issuing operation; highest priority
- func  input  3  op select (RISC-V funct3): 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU
- src_a  input  WIDTH  rs1 operand (multiplicand / dividend)
- src_b  input  WIDTH  rs2 operand (multiplier / divisor)
- busy  output  1  high from the cycle after start is accepted until done
- done  output  1  one-cycle pulse; `result` is valid in this cycle and after
- result  output  WIDTH  registered result; held until the next accepted start

Behaviour:
- Reset: clk is the single clock; rst_n is asynchronous, active-low.
  - Reset forces state=IDLE, busy=0, done=0, result=0, counter=0.
  - Reset mid-operation discards the op; no done pulse.
- States: IDLE, CALC, FINAL.
- IDLE:
  - start=1 and kill=0: latch func, latch operand magnitudes, latch result-sign flags per op signedness. MULHSU: src_a signed, src_b unsigned.
  - Then go to CALC with counter=WIDTH.
  - Special-case divides bypass CALC and go directly to FINAL.
- CALC:
  - Multiply: shift-add, one multiplier bit per cycle into a 2*WIDTH accumulator.
  - Divide: restoring division, one quotient bit per cycle.
  - Counter decrements each cycle; on counter reaching 1, next state is FINAL.
- FINAL:
  - Apply two's-complement sign correction.
  - Select the low half (MUL) or high half (MULH*) of the product, or the quotient/remainder.
  - Register into `result`, pulse done=1, return to IDLE.
- Latency: accepted start at edge N gives done=1 in cycle N+WIDTH+1 (i.e. 33 cycles at WIDTH=32). Special cases give done in cycle N+1.
- Back-to-back: start may be asserted in the same cycle done=1 (state is IDLE after FINAL); it is accepted that cycle.
- start while busy: ignored; operands are not resampled.
- kill: in any state returns to IDLE next edge, with busy=0, no done, and `result` unchanged. kill together with start in IDLE: start is ignored.
- Divide by zero (src_b=0):
  - DIV/DIVU: result = all ones.
  - REM/REMU: result = src_a.
- Signed overflow (DIV/REM with src_a = most negative, src_b = -1):
  - DIV: result = src_a.
  - REM: result = 0.
- Sign rules:
  - Quotient is negative iff operand signs differ and divisor != 0.
  - Remainder takes the sign of the dividend.
  - Products use full 2*WIDTH signed/unsigned semantics.
- busy=1 exactly in the CALC and FINAL states; done and busy are never both 1.

Optional Feature:
- Macro: OTTER_MDU_FAST_MUL_EN.
- Defined:
  - All four multiply ops use a single combinational 2*WIDTH-bit product (DSP inference).
  - IDLE goes directly to FINAL, so multiplies take done at N+1.
  - Divides are unchanged.
- Undefined: multiplies use the iterative CALC path with WIDTH+1 latency, and no hardware multiplier is inferred.
- Port list and handshake are identical in both builds.

Test Plan:
- MUL/MULH, src_a=0xFFFFFFFE (-2), src_b=3 -> MUL=0xFFFFFFFA and MULH=0xFFFFFFFF. done at N+33 (N+1 with OTTER_MDU_FAST_MUL_EN). busy high throughout.
- MULHU and MULHSU, 0xFFFFFFFF x 0xFFFFFFFF:
  - MULHU = 0xFFFFFFFE.
  - MULHSU = 0xFFFFFFFF.
- DIV/REM, src_a=0xFFFFFFF9 (-7), src_b=2 -> DIV=0xFFFFFFFD, REM=0xFFFFFFFF. DIVU 100/7 -> 14; REMU -> 2.
- Special cases, done at N+1:
  - DIVU 5/0 -> 0xFFFFFFFF; REMU 5/0 -> 5.
  - DIV 0x80000000/0xFFFFFFFF -> 0x80000000; REM -> 0.
- kill asserted 10 cycles into a DIV -> busy=0 next cycle, no done, result keeps its prior value. A subsequent start completes normally.
- Handshake:
  - start held high through an op -> no re-issue while busy.
  - New start in the done cycle is accepted.
  - rst_n pulsed low mid-CALC -> all outputs 0 immediately (asynchronous).
